// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD pulse-width counter
// Purpose: FSM state encoding, BCD digit constants and an all-9s vector helper.
// Ports: none (package).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // All-9s pattern for the low `digits` decades; callers slice to 4*DIGITS.
  function automatic logic [31:0] bcd_all9(input int digits);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) v[i*BCD_W +: BCD_W] = BCD_MAX;
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single BCD decade with carry in/out
// Purpose: one decade of the cascaded BCD counter.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   clr_cnt  in   treat the current value as 0 for this edge (clear / new pulse)
//   cin      in   increment request from the lower decade
//   q        out  current digit value
//   q_next   out  value the digit takes at the next edge
//   cout     out  carry to the upper decade
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_cnt,
  input  logic       cin,
  output logic [3:0] q,
  output logic [3:0] q_next,
  output logic       cout
);

  logic [3:0] r_q;
  logic [3:0] w_q_eff;

  // A clear on the same edge as an increment counts from zero, so a new
  // pulse's first count edge lands directly on 1.
  assign w_q_eff = clr_cnt ? 4'd0 : r_q;
  assign cout    = cin & (w_q_eff == BCD_MAX);

  always_comb begin
    q_next = w_q_eff;
    if (cin) q_next = (w_q_eff == BCD_MAX) ? 4'd0 : w_q_eff + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_q <= 4'd0;
    else       r_q <= q_next;
  end

  assign q = r_q;

endmodule

// File: rtl/bcd_pulse_counter.sv
// rtl/bcd_pulse_counter.sv - BCD pulse-width counter for the echo path
// Purpose: measures how long ena stays high in PRESCALE-cycle units using
// DIGITS BCD decades; latches the count on pulse end (or TIMEOUT) and strobes valid.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   ena       in   echo level, already synchronised to clk
//   clr       in   synchronous clear, abandons any measurement
//   count     out  live BCD count, digit k at [4k+3:4k]
//   result    out  BCD value latched at end of last measurement
//   valid     out  one-cycle strobe when result updates
//   overflow  out  last latched result overflowed
//   timeout   out  last latched result was forced by TIMEOUT
//   busy      out  high while the FSM is not IDLE
module bcd_pulse_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 1,
  parameter int TIMEOUT  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                clr,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] result,
  output logic                valid,
  output logic                overflow,
  output logic                timeout,
  output logic                busy
);

  localparam int W  = BCD_W * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [31:0]   ALL9_FULL = bcd_all9(DIGITS);
  localparam logic [W-1:0]  ALL9      = ALL9_FULL[W-1:0];
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [RW-1:0] RAW_MAX   = RW'(TIMEOUT);

  state_t        r_state;
  logic          r_ena_q;
  logic [PW-1:0] r_pre;
  logic [RW-1:0] r_raw;
  logic          r_ovf_int;
  logic [W-1:0]  r_result;
  logic          r_valid;
  logic          r_overflow;
  logic          r_timeout;

  logic          w_rise;
  logic          w_fall;
  logic          w_start;
  logic          w_count_en;
  logic [PW-1:0] w_pre_eff;
  logic          w_tick;
  logic          w_count_all9;
  logic          w_sat_block;
  logic          w_ovf_evt;
  logic          w_ovf_next;
  logic [RW-1:0] w_raw_eff;
  logic [RW-1:0] w_raw_next;
  logic          w_to_hit;
  logic          w_clr_cnt;
  logic [W-1:0]  w_count;
  logic [W-1:0]  w_count_next;
  logic [DIGITS:0] w_carry;

  assign w_rise = ena & ~r_ena_q;
  assign w_fall = ~ena & r_ena_q;

  // clr has priority over the FSM, so it also suppresses a rise on its edge.
  assign w_start    = (r_state == IDLE) & w_rise & ~clr;
  assign w_count_en = ~clr & (w_start | ((r_state == MEASURE) & ena));

  // Prescaler and raw counter restart from zero on the rise edge.
  assign w_pre_eff = w_start ? '0 : r_pre;
  assign w_tick    = w_count_en & (w_pre_eff == PRE_LAST);

  assign w_raw_eff  = w_start ? '0 : r_raw;
  assign w_raw_next = (w_raw_eff == RAW_MAX) ? w_raw_eff : w_raw_eff + 1'b1;
  assign w_to_hit   = (TIMEOUT != 0) & w_count_en & (w_raw_next == RAW_MAX);

  // In saturating mode the increment is blocked at all-9s instead of letting
  // the chain wrap; in wrap mode the top carry itself flags the overflow.
  assign w_count_all9 = ~w_start & (w_count == ALL9);
  assign w_sat_block  = (SATURATE != 0) & w_tick & w_count_all9;
  assign w_carry[0]   = w_tick & ~w_sat_block;
  assign w_ovf_evt    = w_sat_block | w_carry[DIGITS];
  assign w_ovf_next   = (w_start ? 1'b0 : r_ovf_int) | w_ovf_evt;

  assign w_clr_cnt = clr | w_start;

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit u_digit (
        .clk     (clk),
        .reset   (reset),
        .clr_cnt (w_clr_cnt),
        .cin     (w_carry[k]),
        .q       (w_count[k*BCD_W +: BCD_W]),
        .q_next  (w_count_next[k*BCD_W +: BCD_W]),
        .cout    (w_carry[k+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ena_q    <= 1'b1;
      r_pre      <= '0;
      r_raw      <= '0;
      r_ovf_int  <= 1'b0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_ena_q <= ena;
      if (clr) begin
        r_state <= IDLE;
        r_pre   <= '0;
        r_raw   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= 1'b0;
        if (w_count_en) begin
          r_pre     <= w_tick ? '0 : w_pre_eff + 1'b1;
          r_raw     <= w_raw_next;
          r_ovf_int <= w_ovf_next;
        end
        case (r_state)
          IDLE, MEASURE: begin
            if (r_state == MEASURE && w_fall) begin
              r_result   <= w_count;
              r_overflow <= r_ovf_int;
              r_timeout  <= 1'b0;
              r_valid    <= 1'b1;
              r_state    <= IDLE;
            end else if (w_to_hit) begin
              // Forced latch includes this edge's increment.
              r_result   <= w_count_next;
              r_overflow <= w_ovf_next;
              r_timeout  <= 1'b1;
              r_valid    <= 1'b1;
              r_state    <= WAIT_LOW;
            end else if (w_start) begin
              r_state <= MEASURE;
            end
          end
          WAIT_LOW: begin
            if (w_fall) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign count    = w_count;
  assign result   = r_result;
  assign valid    = r_valid;
  assign overflow = r_overflow;
  assign timeout  = r_timeout;
  assign busy     = (r_state != IDLE);

endmodule
